// File: rtl/sr_monitor.sv
// sr_monitor
//
// Multi-channel correlation run monitor. It samples N_CH correlator status
// words and follows one correlation run from launch to completion. It keeps
// sticky per-channel done and failure flags and enforces an optional run
// timeout. When the run ends, it raises a held interrupt toward the master
// controller.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   sr             N_CH status words, channel i at sr[i*SR_W +: SR_W]
//   ch_enable      channels taking part in the run, latched on accepted start
//   timeout_cycles run timeout in clk cycles, latched on accepted start, 0 = none
//   start          one-cycle run launch pulse, ignored while a run is active
//   irq_ack        clears irq
//   corr_busy      per channel: run active, enabled, done not yet seen
//   fail_ch        sticky per-channel failure flags of the current/last run
//   failure        OR of fail_ch
//   timeout        sticky: last run ended by timeout
//   all_done       last run completed with every enabled channel done
//   irq            end-of-run interrupt, held until acknowledged or restarted
//   state          0 IDLE, 1 RUN, 2 DONE, 3 ERROR

module sr_monitor #(
  parameter int N_CH     = 4,
  parameter int SR_W     = 32,
  parameter int DONE_BIT = 0,
  parameter int FAIL_BIT = 1,
  parameter int TMO_W    = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH*SR_W-1:0] sr,
  input  logic [N_CH-1:0]      ch_enable,
  input  logic [TMO_W-1:0]     timeout_cycles,
  input  logic                 start,
  input  logic                 irq_ack,
  output logic [N_CH-1:0]      corr_busy,
  output logic [N_CH-1:0]      fail_ch,
  output logic                 failure,
  output logic                 timeout,
  output logic                 all_done,
  output logic                 irq,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t                state_q;
  logic [N_CH*SR_W-1:0]  sr_q;
  logic [N_CH-1:0]       mask;
  logic [N_CH-1:0]       done_seen;
  logic [TMO_W-1:0]      counter;

  logic [N_CH-1:0]       done_q;
  logic [N_CH-1:0]       fail_q;
  logic                  run_fail;
  logic                  run_done;
  logic                  run_tmo;
  logic                  unused_sr_bits;

  // Every status word is registered once before use. All decisions are made
  // on sr_q only, so a change on sr takes effect one edge after it is sampled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr;
    end
  end

  // Pull the done and failure bits out of each registered status word.
  always_comb begin
    done_q = '0;
    fail_q = '0;
    for (int i = 0; i < N_CH; i++) begin
      done_q[i] = sr_q[i*SR_W + DONE_BIT];
      fail_q[i] = sr_q[i*SR_W + FAIL_BIT];
    end
  end

  // The other status bits are sampled along with the rest of the word but
  // have no meaning for this monitor.
  assign unused_sr_bits = ^sr_q;

  // RUN exit conditions. Failure has the highest priority, then completion,
  // then timeout. Completion counts done bits already seen and done bits
  // arriving this cycle. An empty mask therefore completes at once.
  // The counter only holds 1 when a non-zero timeout was latched, so
  // "counter == 1" also implies that the timeout is enabled.
  assign run_fail = |(fail_q & mask);
  assign run_done = (((done_seen | done_q) & mask) == mask);
  assign run_tmo  = (counter == TMO_W'(1));

  // Main run FSM together with all sticky flags and the interrupt.
  // An accepted start re-arms every flag and latches the channel mask and
  // timeout. While in RUN, flags accumulate each edge and the counter runs
  // down until the run exits. DONE and ERROR freeze everything until the
  // next start. The irq acknowledge is applied first, so entering DONE or
  // ERROR on the same edge still leaves irq set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mask      <= '0;
      done_seen <= '0;
      fail_ch   <= '0;
      timeout   <= 1'b0;
      all_done  <= 1'b0;
      irq       <= 1'b0;
      counter   <= '0;
    end else begin
      if (irq_ack) begin
        irq <= 1'b0;
      end
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state_q   <= ST_RUN;
            mask      <= ch_enable;
            counter   <= timeout_cycles;
            done_seen <= '0;
            fail_ch   <= '0;
            timeout   <= 1'b0;
            all_done  <= 1'b0;
            irq       <= 1'b0;
          end
        end
        ST_RUN: begin
          done_seen <= done_seen | (done_q & mask);
          fail_ch   <= fail_ch | (fail_q & mask);
          if (counter != '0) begin
            counter <= counter - TMO_W'(1);
          end
          if (run_fail) begin
            state_q <= ST_ERROR;
            irq     <= 1'b1;
          end else if (run_done) begin
            state_q  <= ST_DONE;
            all_done <= 1'b1;
            irq      <= 1'b1;
          end else if (run_tmo) begin
            state_q <= ST_ERROR;
            timeout <= 1'b1;
            irq     <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Status decode. It comes from registers only, so there is no
  // combinational path from sr to any output.
  assign corr_busy = (state_q == ST_RUN) ? (mask & ~done_seen) : '0;
  assign failure   = |fail_ch;
  assign state     = state_q;

endmodule
